// File: rtl/linked_list_ctrl_if.sv
// Handshake and memory-bus bundle for linked_list_ctrl.
// The slave modport is the controller; the master side is the requesters and the memory.
interface linked_list_ctrl_if #(
  parameter int WR_ADDR_WD = 4,
  parameter int WR_DATA_WD = 8
);
  logic                  push_vld;
  logic [WR_DATA_WD-1:0] push_data;
  logic                  push_rdy;
  logic                  pop_vld;
  logic                  pop_rdy;
  logic [WR_DATA_WD-1:0] pop_data;
  logic                  pop_data_vld;
  logic [WR_ADDR_WD:0]   count;
  logic                  empty;
  logic                  full;
  logic                  init_busy;
  logic                  mem_wr_vld;
  logic [WR_ADDR_WD-1:0] mem_wr_addr;
  logic [WR_DATA_WD-1:0] mem_wr_data;
  logic                  mem_wr_done;
  logic                  mem_rd_vld;
  logic [WR_ADDR_WD-1:0] mem_rd_addr;
  logic [WR_DATA_WD-1:0] mem_rd_data;
  logic                  mem_rd_data_out_vld;

  modport slave (
    input  push_vld, push_data, pop_vld,
    input  mem_wr_done, mem_rd_data, mem_rd_data_out_vld,
    output push_rdy, pop_rdy, pop_data, pop_data_vld,
    output count, empty, full, init_busy,
    output mem_wr_vld, mem_wr_addr, mem_wr_data,
    output mem_rd_vld, mem_rd_addr
  );

  modport master (
    output push_vld, push_data, pop_vld,
    output mem_wr_done, mem_rd_data, mem_rd_data_out_vld,
    input  push_rdy, pop_rdy, pop_data, pop_data_vld,
    input  count, empty, full, init_busy,
    input  mem_wr_vld, mem_wr_addr, mem_wr_data,
    input  mem_rd_vld, mem_rd_addr
  );
endinterface

// File: rtl/linked_list_ctrl.sv
// Linked-list FIFO controller: owns the data memory, keeps a FIFO list and a free list
// threaded through one next-pointer table, and round-robins push and pop requests.
module linked_list_ctrl #(
  parameter int WR_ADDR_WD = 4,
  parameter int WR_DATA_WD = 8,
  parameter int DATA_DEPTH = 16
) (
  input logic              clk,
  input logic              reset_n,
  linked_list_ctrl_if.slave bus
);

  typedef enum logic [1:0] {INIT, IDLE, WR_WAIT, RD_WAIT} state_e;
  typedef enum logic {GRANT_POP, GRANT_PUSH} grant_e;

  // DATA_DEPTH must equal 2**WR_ADDR_WD so the init index and pointers wrap naturally.
  localparam logic [WR_ADDR_WD-1:0] LAST_IDX = WR_ADDR_WD'(DATA_DEPTH - 1);
  localparam logic [WR_ADDR_WD:0]   FULL_CNT = (WR_ADDR_WD + 1)'(DATA_DEPTH);

  state_e                state;
  state_e                state_nxt;
  grant_e                last_grant;
  logic [WR_ADDR_WD-1:0] next_ptr [DATA_DEPTH];
  logic [WR_ADDR_WD-1:0] init_idx;
  logic [WR_ADDR_WD-1:0] head;
  logic [WR_ADDR_WD-1:0] tail;
  logic [WR_ADDR_WD-1:0] free_head;
  logic [WR_ADDR_WD:0]   count_q;
  logic [WR_DATA_WD-1:0] pop_data_q;
  logic                  pop_data_vld_q;
  logic                  list_empty;
  logic                  list_full;
  logic                  push_elig;
  logic                  pop_elig;
  logic                  push_grant;
  logic                  pop_grant;

  assign list_empty = (count_q == '0);
  assign list_full  = (count_q == FULL_CNT);

  // Both requesters eligible: grant the side that did not win last time.
  always_comb begin
    push_elig  = bus.push_vld && !list_full;
    pop_elig   = bus.pop_vld && !list_empty;
    push_grant = 1'b0;
    pop_grant  = 1'b0;
    state_nxt  = state;
    case (state)
      INIT: begin
        if (init_idx == LAST_IDX) state_nxt = IDLE;
      end
      IDLE: begin
        if (push_elig && (!pop_elig || last_grant == GRANT_POP)) begin
          push_grant = 1'b1;
          state_nxt  = WR_WAIT;
        end else if (pop_elig) begin
          pop_grant = 1'b1;
          state_nxt = RD_WAIT;
        end
      end
      WR_WAIT: begin
        if (bus.mem_wr_done) state_nxt = IDLE;
      end
      RD_WAIT: begin
        if (bus.mem_rd_data_out_vld) state_nxt = IDLE;
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= INIT;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      init_idx   <= '0;
      head       <= '0;
      tail       <= '0;
      free_head  <= '0;
      count_q    <= '0;
      last_grant <= GRANT_POP;
    end else begin
      if (state == INIT) init_idx <= init_idx + 1'b1;
      if (push_grant) begin
        free_head  <= next_ptr[free_head];
        if (list_empty) head <= free_head;
        tail       <= free_head;
        count_q    <= count_q + 1'b1;
        last_grant <= GRANT_PUSH;
      end else if (pop_grant) begin
        head       <= next_ptr[head];
        free_head  <= head;
        count_q    <= count_q - 1'b1;
        last_grant <= GRANT_POP;
      end
    end
  end

  // The pointer table needs no reset: INIT rebuilds every entry before the list is used.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (state == INIT)                 next_ptr[init_idx] <= init_idx + 1'b1;
      else if (push_grant && !list_empty) next_ptr[tail]    <= free_head;
      else if (pop_grant)                 next_ptr[head]    <= free_head;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pop_data_q     <= '0;
      pop_data_vld_q <= 1'b0;
    end else if (state == RD_WAIT && bus.mem_rd_data_out_vld) begin
      pop_data_q     <= bus.mem_rd_data;
      pop_data_vld_q <= 1'b1;
    end else begin
      pop_data_vld_q <= 1'b0;
    end
  end

  assign bus.push_rdy     = push_grant;
  assign bus.pop_rdy      = pop_grant;
  assign bus.pop_data     = pop_data_q;
  assign bus.pop_data_vld = pop_data_vld_q;
  assign bus.count        = count_q;
  assign bus.empty        = list_empty;
  assign bus.full         = list_full;
  assign bus.init_busy    = (state == INIT);
  assign bus.mem_wr_vld   = push_grant;
  assign bus.mem_wr_addr  = free_head;
  assign bus.mem_wr_data  = bus.push_data;
  assign bus.mem_rd_vld   = pop_grant;
  assign bus.mem_rd_addr  = head;

endmodule
